// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   PC register and fetch stage in front of a combinational, byte-addressed
//   instruction memory. The fetched word and its PC are captured into an
//   IF/ID register and handed to decode over a valid/ready handshake.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   Instruction    word returned by the memory for Instr_Addr (same cycle)
//   Instr_Addr     fetch address, always equal to the PC register
//   branch_taken   redirect request from execute
//   branch_target  redirect address, meaningful when branch_taken=1
//   stall          hazard stall, freezes PC and the IF/ID register
//   id_ready       decode accepts if_instr/if_pc this cycle
//   if_valid       IF/ID register holds a valid instruction
//   if_instr       registered instruction
//   if_pc          PC of if_instr
//   fetch_done     PC has run past the last legal fetch address
//   addr_fault     sticky: a redirect targeted a misaligned address
//
// state   | meaning
// S_RUN   | fetching sequentially
// S_DONE  | PC past end of memory, no new captures, output may drain
// S_FAULT | misaligned redirect seen, frozen until reset

module instr_fetch_unit #(
  parameter int unsigned            ADDR_W     = 64,
  parameter int unsigned            INSTR_W    = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC   = '0,
  parameter int unsigned            IMEM_BYTES = 76
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  Instr_Addr,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               fetch_done,
  output logic               addr_fault
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DONE  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    w_pc_nxt;
  logic [ADDR_W-1:0]    w_pc_plus4;
  logic                 r_valid;
  logic                 w_valid_nxt;
  logic                 w_capture;
  logic                 w_advance;
  logic [INSTR_W-1:0]   r_instr;
  logic [ADDR_W-1:0]    r_if_pc;

  assign w_pc_plus4 = r_pc + ADDR_W'(4);
  assign w_advance  = (r_state == S_RUN) && !stall && (!r_valid || id_ready);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_capture   = 1'b0;
    // Redirect outranks stall, backpressure and advance; FAULT ignores it.
    if (branch_taken && (r_state != S_FAULT)) begin
      w_valid_nxt = 1'b0;
      if (branch_target[1:0] == 2'b00) begin
        w_pc_nxt    = branch_target;
        w_state_nxt = (branch_target > LAST_ADDR) ? S_DONE : S_RUN;
      end else begin
        w_state_nxt = S_FAULT;
      end
    end else if (w_advance) begin
      w_capture   = 1'b1;
      w_valid_nxt = 1'b1;
      w_pc_nxt    = w_pc_plus4;
      if (w_pc_plus4 > LAST_ADDR) begin
        w_state_nxt = S_DONE;
      end
    end else if (id_ready && r_valid) begin
      // consume without a new capture (stall, DONE or FAULT)
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_if_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      if (w_capture) begin
        r_instr <= Instruction;
        r_if_pc <= r_pc;
      end
    end
  end

  assign Instr_Addr = r_pc;
  assign if_valid   = r_valid;
  assign if_instr   = r_instr;
  assign if_pc      = r_if_pc;
  assign fetch_done = (r_state == S_DONE);
  assign addr_fault = (r_state == S_FAULT);

endmodule
